// File: rtl/adc_spi_pkg.sv
// Shared constants, state type and frame-building helper for the ADC SPI responder.
package adc_spi_pkg;

  localparam int FRAME_BITS  = 16;
  localparam int LEAD_ZEROS  = 3;
  localparam int DATA_BITS   = 8;
  localparam int TRAIL_ZEROS = 5;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  // Place the sample between the leading and trailing zero padding of a frame.
  function automatic logic [FRAME_BITS-1:0] build_tx_word(input logic [DATA_BITS-1:0] sample);
    return {{LEAD_ZEROS{1'b0}}, sample, {TRAIL_ZEROS{1'b0}}};
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one SPI pin with an optional rise/fall detector.
// Edges are suppressed until the chain holds genuine pin samples, so a pin that
// already sits away from its reset value after reset does not look like an edge.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1,
  parameter bit   EDGE_EN   = 1'b1
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Pin,
  output logic o_Level,
  output logic o_Rise,
  output logic o_Fall
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw pin through the synchronizer chain.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], i_Pin};
    end
  end

  assign o_Level = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic            prev_q;
      logic [STAGES:0] fill_q;
      logic            edges_ok;

      // Remember the previous synced level and track when the chain has filled.
      always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
          prev_q <= RESET_VAL;
          fill_q <= '0;
        end else begin
          prev_q <= o_Level;
          fill_q <= {fill_q[STAGES-1:0], 1'b1};
        end
      end

      assign edges_ok = fill_q[STAGES];
      assign o_Rise   = edges_ok &  o_Level & ~prev_q;
      assign o_Fall   = edges_ok & ~o_Level &  prev_q;
    end else begin : g_no_edge
      assign o_Rise = 1'b0;
      assign o_Fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/adc_spi_responder.sv
// SPI Mode 3 responder emulating an 8-bit ambient-light ADC. Serves
// {3'b000, sample, 5'b00000} MSB-first per chip-select and captures the
// 16 MOSI bits of each complete frame. All logic runs on i_Clk by
// oversampling the SPI pins.
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic [DATA_BITS-1:0]  i_Sample,
  input  logic                  i_Sample_DV,
  input  logic                  i_SPI_Clk,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic                  o_SPI_MISO_En,
  output logic [FRAME_BITS-1:0] o_RX_Word,
  output logic                  o_RX_DV,
  output logic                  o_Frame_Err,
  output logic                  o_Busy
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  state_t                 state;
  logic [FRAME_BITS-1:0]  tx_shift;
  logic [FRAME_BITS-1:0]  rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_BITS-1:0]   sample_hold;

  logic unused_sigs;

  spi_pin_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1),
    .EDGE_EN   (1'b1)
  ) u_sclk_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Pin   (i_SPI_Clk),
    .o_Level (sclk_level),
    .o_Rise  (sclk_rise),
    .o_Fall  (sclk_fall)
  );

  spi_pin_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1),
    .EDGE_EN   (1'b1)
  ) u_cs_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Pin   (i_SPI_CS_n),
    .o_Level (cs_level),
    .o_Rise  (cs_rise),
    .o_Fall  (cs_fall)
  );

  spi_pin_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0),
    .EDGE_EN   (1'b0)
  ) u_mosi_sync (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Pin   (i_SPI_MOSI),
    .o_Level (mosi_level),
    .o_Rise  (mosi_rise),
    .o_Fall  (mosi_fall)
  );

  assign unused_sigs = ^{sclk_level, mosi_rise, mosi_fall};

  // Hold the most recently strobed sample until the next frame picks it up.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sample_hold <= '0;
    end else if (i_Sample_DV) begin
      sample_hold <= i_Sample;
    end
  end

  // Enable the MISO pad whenever the synchronized chip select is low.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_SPI_MISO_En <= 1'b0;
    end else begin
      o_SPI_MISO_En <= ~cs_level;
    end
  end

  // Frame state machine: shifts data out on SCLK falls, captures on rises.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      o_SPI_MISO  <= 1'b0;
      o_RX_Word   <= '0;
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Busy      <= 1'b0;
    end else begin
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          o_SPI_MISO <= 1'b0;
          if (cs_fall) begin
            tx_shift <= build_tx_word(sample_hold);
            rx_shift <= '0;
            bit_cnt  <= '0;
            o_Busy   <= 1'b1;
            state    <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (cs_rise) begin
            o_Frame_Err <= 1'b1;
            rx_shift    <= '0;
            o_SPI_MISO  <= 1'b0;
            o_Busy      <= 1'b0;
            state       <= IDLE;
          end else if (sclk_fall) begin
            o_SPI_MISO <= tx_shift[FRAME_BITS-1];
            tx_shift   <= {tx_shift[FRAME_BITS-2:0], 1'b0};
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_level};
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
              o_RX_Word  <= {rx_shift[FRAME_BITS-2:0], mosi_level};
              o_RX_DV    <= 1'b1;
              o_SPI_MISO <= 1'b0;
              state      <= DONE;
            end
          end
        end

        DONE: begin
          o_SPI_MISO <= 1'b0;
          if (cs_rise) begin
            o_Busy <= 1'b0;
            state  <= IDLE;
          end
        end

        default: begin
          o_SPI_MISO <= 1'b0;
          o_Busy     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
